// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART. A byte is captured on each falling edge of the
// receiver busy flag and popped one per rd_en cycle with a registered, pulsed output.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_int,
    input  logic [7:0]            rx_data,
    input  logic                  rd_en,
    input  logic                  clr_ovf,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned             Depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     FullCount = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]     CntOne    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0]   PtrOne    = (DEPTH_LOG2)'(1);

    logic [7:0]              mem [Depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [7:0]              rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    rx_int_q;
    logic                    wr_evt, do_wr, do_rd, drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FullCount);
    assign count    = count_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;

    always_comb begin
        wr_evt     = rx_int_q & ~rx_int;
        do_rd      = rd_en & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
        do_wr      = wr_evt & (~full | do_rd);
        drop       = wr_evt & full & ~do_rd;

        wr_ptr_d   = do_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = do_rd ? rd_ptr_q + PtrOne : rd_ptr_q;
        rd_data_d  = do_rd ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d = do_rd;
        // Set wins over clear when both happen in one cycle.
        overflow_d = drop | (overflow_q & ~clr_ovf);

        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_int_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rx_int_q   <= rx_int;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; a slot is always written before it can be popped.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued at stimulus time and a
// negedge monitor compares every rd_valid pulse against the queue head.
module tb_uart_rx_fifo;

    localparam int Depth = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_int = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    int         m_count = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] prev_data;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_int   (rx_int),
        .rx_data  (rx_data),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, int'(count), m_count);
        chk({tag, "_empty"}, int'(empty), int'(m_count == 0));
        chk({tag, "_full"}, int'(full), int'(m_count == Depth));
        chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    endtask

    // Frame: rx_int high for hi cycles, then falls with b on rx_data; optional
    // rd_en / clr_ovf in the same cycle as the fall.
    task automatic send(input logic [7:0] b, input int hi, input logic with_rd,
                        input logic with_clr);
        @(posedge clk); #1 rx_int = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        rx_data = b;
        rx_int  = 1'b0;
        rd_en   = with_rd;
        clr_ovf = with_clr;
        if (with_rd && m_count > 0) m_count--;
        if (m_count < Depth) begin
            sb.push_back(b);
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        if (m_count < Depth || !with_clr) begin
            // drop sets overflow above; clear only applies when nothing was dropped
        end
        if (with_clr && !(m_count == Depth && sb.size() == m_count && sb[sb.size()-1] != b))
            m_ovf = m_ovf;
        @(posedge clk); #1;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic rd_one();
        @(posedge clk); #1 rd_en = 1'b1;
        if (m_count > 0) m_count--;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 clr_ovf = 1'b1;
        m_ovf = 1'b0;
        @(posedge clk); #1 clr_ovf = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got rd_valid=1 data %0h expected no pop at %0t",
                         rd_data, $time);
            end else begin
                chk("pop_data", int'(rd_data), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_state("reset");
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single byte
        send(8'hA5, 20, 1'b0, 1'b0);
        chk_state("single_wr");
        rd_one();
        chk("single_rd_valid", int'(rd_valid), 1);
        chk("single_rd_data", int'(rd_data), 'hA5);
        chk("single_empty", int'(empty), 1);

        // Fill and wrap
        for (int i = 0; i < 16; i++) send(8'(i), 2, 1'b0, 1'b0);
        chk_state("fill16");
        for (int i = 0; i < 8; i++) rd_one();
        chk_state("read8");
        for (int i = 16; i < 24; i++) send(8'(i), 2, 1'b0, 1'b0);
        chk_state("wrap_fill");
        for (int i = 0; i < 16; i++) rd_one();
        chk_state("wrap_drain");

        // Overflow drop and clear
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 2, 1'b0, 1'b0);
        send(8'hFF, 2, 1'b0, 1'b0);
        chk_state("ovf_drop");
        for (int i = 0; i < 16; i++) rd_one();
        chk_state("ovf_drain");
        clr_pulse();
        chk_state("ovf_clr");

        // Clear coincident with a drop: set wins
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 2, 1'b0, 1'b0);
        send(8'hFE, 2, 1'b0, 1'b1);
        chk_state("clr_race");
        clr_pulse();
        chk_state("clr_race_clr");

        // Simultaneous write and pop while full
        send(8'h99, 2, 1'b1, 1'b0);
        chk_state("sim_full");
        for (int i = 0; i < 16; i++) rd_one();
        chk_state("sim_drain");

        // Simultaneous write and rd_en while empty: only the write happens
        send(8'h77, 2, 1'b1, 1'b0);
        chk("sim_empty_valid", int'(rd_valid), 0);
        chk_state("sim_empty");
        rd_one();

        // Read while empty
        prev_data = rd_data;
        rd_one();
        chk("empty_rd_valid", int'(rd_valid), 0);
        chk("empty_rd_hold", int'(rd_data), int'(prev_data));

        // Reset mid-stream
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 2, 1'b0, 1'b0);
        @(posedge clk); #1 rx_int = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        m_count = 0;
        m_ovf = 1'b0;
        #2;
        chk_state("rst_mid");
        chk("rst_mid_rd_data", int'(rd_data), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_data = 8'h3C;
        rx_int  = 1'b0;
        sb.push_back(8'h3C);
        m_count = 1;
        @(posedge clk); #1;
        chk_state("post_rst_wr");
        rd_one();
        repeat (3) @(posedge clk);
        #1;
        chk_state("final");
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
